// File: rtl/alu_pkg.sv
// Shared definitions for the parameterised ALU: opcodes, flag bit positions, FSM states.
package alu_pkg;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_CLR = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_MPY = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_OR  = 4'd6;
  localparam logic [3:0] OP_NOT = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;
  localparam logic [3:0] OP_SAR = 4'd10;
  localparam logic [3:0] OP_CMP = 4'd11;

  // Flag bit positions inside the 4-bit flags word
  localparam int FL_N = 0;
  localparam int FL_Z = 1;
  localparam int FL_V = 2;
  localparam int FL_H = 3;

  // Flags after reset / CLR: only Z set
  localparam logic [3:0] FLAGS_RST = 4'b0010;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/param_alu_if.sv
// Request/result bus of the parameterised ALU; the ALU is the slave side.
interface param_alu_if #(
  parameter int WIDTH = 16
) ();

  logic             op_valid;
  logic             op_ready;
  logic [3:0]       op_code;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] res_lo;
  logic [WIDTH-1:0] res_hi;
  logic             res_valid;
  logic [3:0]       flags;

  modport master (
    output op_valid, op_code, a_in, b_in,
    input  op_ready, res_lo, res_hi, res_valid, flags
  );

  modport slave (
    input  op_valid, op_code, a_in, b_in,
    output op_ready, res_lo, res_hi, res_valid, flags
  );

endinterface

// File: rtl/alu_mul_seq.sv
// Sequential signed multiplier: one partial product per cycle, WIDTH iterations.
// The last iteration is combinational, so o_done/o_product are valid in the
// cycle before the edge WIDTH cycles after i_start was sampled.
module alu_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_start,
  input  logic signed [WIDTH-1:0]   i_a,
  input  logic signed [WIDTH-1:0]   i_b,
  output logic                      o_done,
  output logic signed [2*WIDTH-1:0] o_product
);

  localparam int CW = $clog2(WIDTH);
  localparam int PW = 2 * WIDTH;

  logic                 r_busy;
  logic [CW-1:0]        r_cnt;
  logic signed [PW-1:0] r_acc;
  logic signed [PW-1:0] r_mcand;
  logic [WIDTH-1:0]     r_mplier;

  logic                 w_last;
  logic signed [PW-1:0] w_pp;
  logic signed [PW-1:0] w_acc_nxt;

  // Partial product for the current multiplier bit; the sign bit has negative weight,
  // and the 2*WIDTH-bit accumulator holds even (-2^(W-1))^2 exactly
  always_comb begin
    w_last    = (r_cnt == CW'(WIDTH - 1));
    w_pp      = '0;
    if (r_mplier[0]) begin
      w_pp = w_last ? -r_mcand : r_mcand;
    end
    w_acc_nxt = r_acc + w_pp;
  end

  assign o_done    = r_busy && w_last;
  assign o_product = w_acc_nxt;

  // Iteration control; reset aborts a running multiply
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
    end else if (r_busy) begin
      if (w_last) begin
        r_busy <= 1'b0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // Shift-add datapath; only meaningful while busy, so it carries no reset
  always_ff @(posedge clk) begin
    if (i_start) begin
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{i_a[WIDTH-1]}}, i_a};
      r_mplier <= i_b;
    end else if (r_busy) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand <<< 1;
      r_mplier <= r_mplier >> 1;
    end
  end

endmodule

// File: rtl/param_alu.sv
// Parameterised ALU: single-cycle arithmetic/logic ops plus a WIDTH-cycle signed multiply.
module param_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  param_alu_if.slave  alu
);

  state_t r_state;
  state_t w_state_nxt;

  logic                       w_ready;
  logic                       w_accept;
  logic                       w_mul_start;
  logic                       w_mul_done;
  logic signed [2*WIDTH-1:0]  w_prod;

  logic signed [WIDTH-1:0]    w_a;
  logic signed [WIDTH-1:0]    w_b;
  logic signed [WIDTH-1:0]    w_sum;
  logic signed [WIDTH-1:0]    w_diff;
  logic signed [WIDTH-1:0]    w_res;
  logic                       w_v;
  logic                       w_wr_res;
  logic                       w_wr_flags;

  logic [WIDTH-1:0]           r_lo;
  logic [WIDTH-1:0]           r_hi;
  logic [3:0]                 r_flags;
  logic                       r_valid;

  function automatic logic add_ovf(input logic signed [WIDTH-1:0] a,
                                   input logic signed [WIDTH-1:0] b,
                                   input logic signed [WIDTH-1:0] s);
    add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
  endfunction

  function automatic logic sub_ovf(input logic signed [WIDTH-1:0] a,
                                   input logic signed [WIDTH-1:0] b,
                                   input logic signed [WIDTH-1:0] d);
    sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (d[WIDTH-1] != a[WIDTH-1]);
  endfunction

  function automatic logic [3:0] res_flags(input logic signed [WIDTH-1:0] r, input logic v);
    res_flags       = '0;
    res_flags[FL_N] = r[WIDTH-1];
    res_flags[FL_Z] = (r == '0);
    res_flags[FL_V] = v;
  endfunction

  function automatic logic [3:0] mul_flags(input logic signed [2*WIDTH-1:0] p);
    mul_flags       = '0;
    mul_flags[FL_N] = p[2*WIDTH-1];
    mul_flags[FL_Z] = (p == '0);
    mul_flags[FL_H] = 1'b1;
  endfunction

  assign w_a         = alu.a_in;
  assign w_b         = alu.b_in;
  assign w_accept    = alu.op_valid && w_ready;
  assign w_mul_start = w_accept && (alu.op_code == OP_MPY);

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_mul_start),
    .i_a       (w_a),
    .i_b       (w_b),
    .o_done    (w_mul_done),
    .o_product (w_prod)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and ready: accept only in IDLE, stay in MUL until the product lands
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
        if (alu.op_valid && (alu.op_code == OP_MPY)) begin
          w_state_nxt = ST_MUL;
        end
      end
      ST_MUL: begin
        if (w_mul_done) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Single-cycle result and overflow; CMP updates flags only, NOP/MPY write nothing here
  always_comb begin
    w_sum      = w_a + w_b;
    w_diff     = w_a - w_b;
    w_res      = '0;
    w_v        = 1'b0;
    w_wr_res   = 1'b0;
    w_wr_flags = 1'b0;
    case (alu.op_code)
      OP_CLR: begin w_res = '0;           w_wr_res = 1'b1; w_wr_flags = 1'b1; end
      OP_ADD: begin w_res = w_sum;        w_v = add_ovf(w_a, w_b, w_sum);
                    w_wr_res = 1'b1;      w_wr_flags = 1'b1; end
      OP_SUB: begin w_res = w_diff;       w_v = sub_ovf(w_a, w_b, w_diff);
                    w_wr_res = 1'b1;      w_wr_flags = 1'b1; end
      OP_CMP: begin w_res = w_diff;       w_v = sub_ovf(w_a, w_b, w_diff);
                    w_wr_flags = 1'b1; end
      OP_AND: begin w_res = w_a & w_b;    w_wr_res = 1'b1; w_wr_flags = 1'b1; end
      OP_OR:  begin w_res = w_a | w_b;    w_wr_res = 1'b1; w_wr_flags = 1'b1; end
      OP_NOT: begin w_res = ~w_a;         w_wr_res = 1'b1; w_wr_flags = 1'b1; end
      OP_SHL: begin w_res = w_a << 1;     w_wr_res = 1'b1; w_wr_flags = 1'b1; end
      OP_SHR: begin w_res = $signed({1'b0, w_a[WIDTH-1:1]});
                    w_wr_res = 1'b1;      w_wr_flags = 1'b1; end
      OP_SAR: begin w_res = w_a >>> 1;    w_wr_res = 1'b1; w_wr_flags = 1'b1; end
      default: begin end
    endcase
  end

  // Result/flag registers and the one-cycle result strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lo    <= '0;
      r_hi    <= '0;
      r_flags <= FLAGS_RST;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_mul_done) begin
        r_lo    <= w_prod[WIDTH-1:0];
        r_hi    <= w_prod[2*WIDTH-1:WIDTH];
        r_flags <= mul_flags(w_prod);
        r_valid <= 1'b1;
      end else if (w_accept && (alu.op_code != OP_MPY)) begin
        r_valid <= 1'b1;
        if (w_wr_res) begin
          r_lo <= w_res;
          r_hi <= '0;
        end
        if (w_wr_flags) begin
          r_flags <= res_flags(w_res, w_v);
        end
      end
    end
  end

  assign alu.op_ready  = w_ready;
  assign alu.res_lo    = r_lo;
  assign alu.res_hi    = r_hi;
  assign alu.flags     = r_flags;
  assign alu.res_valid = r_valid;

endmodule

// File: tb/tb_param_alu.sv
// Scoreboard bench for param_alu at WIDTH=16: expected results are queued at drive time
// and popped when res_valid is observed.
module tb_param_alu;
  import alu_pkg::*;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  param_alu_if #(.WIDTH(W)) bus ();

  param_alu #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .alu   (bus)
  );

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic [3:0]   fl;
    int           lat;
    string        name;
  } exp_t;

  exp_t sb[$];
  logic [W-1:0] m_lo = '0;
  logic [W-1:0] m_hi = '0;
  logic [3:0]   m_fl = 4'b0010;
  int total = 0;
  int bad   = 0;

  // Reference model: computes the expected outcome from integer arithmetic
  function automatic void push_exp(input logic [3:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input string nm);
    exp_t e;
    longint sa, sbv, r, lim;
    logic [W-1:0] res;
    logic [2*W-1:0] p;
    logic v;
    bit wr;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    lim = longint'(1) <<< (W - 1);
    e.lo = m_lo; e.hi = m_hi; e.fl = m_fl; e.lat = 0; e.name = nm;
    res = '0; v = 1'b0; wr = 1'b1; r = 0;
    case (op)
      OP_CLR: res = '0;
      OP_ADD: begin r = sa + sbv; res = r[W-1:0]; v = (r >= lim) || (r < -lim); end
      OP_SUB, OP_CMP: begin r = sa - sbv; res = r[W-1:0]; v = (r >= lim) || (r < -lim); end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_NOT: res = ~a;
      OP_SHL: res = {a[W-2:0], 1'b0};
      OP_SHR: res = {1'b0, a[W-1:1]};
      OP_SAR: res = {a[W-1], a[W-1:1]};
      default: wr = 1'b0;
    endcase
    if (op == OP_MPY) begin
      r = sa * sbv;
      p = r[2*W-1:0];
      e.hi = p[2*W-1:W];
      e.lo = p[W-1:0];
      e.fl = {1'b1, 1'b0, (p == '0), p[2*W-1]};
      e.lat = W;
    end else if (wr) begin
      e.fl = {1'b0, v, (res == '0), res[W-1]};
      if (op != OP_CMP) begin
        e.lo = res;
        e.hi = '0;
      end
    end
    m_lo = e.lo; m_hi = e.hi; m_fl = e.fl;
    sb.push_back(e);
  endfunction

  // Drive one op for one accept edge, then wait (bounded) for res_valid
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input string nm, output bit seen, output int lat);
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op_code = op; bus.a_in = a; bus.b_in = b;
    push_exp(op, a, b, nm);
    @(posedge clk);
    @(negedge clk);
    bus.op_valid = 1'b0;
    lat = 0;
    while (!bus.res_valid && lat < W + 4) begin
      @(negedge clk);
      lat++;
    end
    seen = bus.res_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (bus.res_lo !== '0 || bus.res_hi !== '0) begin
      bad++; $display("FAIL reset_res: got hi=%h lo=%h want 0000 0000", bus.res_hi, bus.res_lo);
    end
    total++;
    if (bus.flags !== 4'b0010) begin
      bad++; $display("FAIL reset_flags: got %b want 0010", bus.flags);
    end
    total++;
    if (bus.res_valid !== 1'b0 || bus.op_ready !== 1'b1) begin
      bad++; $display("FAIL reset_hs: got valid=%b ready=%b want 0 1", bus.res_valid, bus.op_ready);
    end
    rst_n = 1'b1;
  endtask

  // Single-cycle ops from a table: result one cycle after accept, strobe lasts one cycle
  task automatic test_single();
    logic [3:0]   ops[16] = '{OP_CLR, OP_ADD, OP_SUB, OP_CMP, OP_ADD, OP_SUB, OP_AND, OP_OR,
                              OP_NOT, OP_SHL, OP_SAR, OP_SHR, OP_NOP, 4'd13, OP_CLR, 4'd15};
    logic [W-1:0] av[16]  = '{16'h1234, 16'h7FFF, 16'h0005, 16'h0003, 16'h8000, 16'h8000, 16'hF0F0,
                              16'hF0F0, 16'h00FF, 16'hC001, 16'h8004, 16'h8004, 16'hAAAA, 16'h5555,
                              16'h0001, 16'h0000};
    logic [W-1:0] bv[16]  = '{16'h5678, 16'h0001, 16'h0005, 16'h0005, 16'h8000, 16'h0001, 16'h3C3C,
                              16'h0F0F, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h5555, 16'hAAAA,
                              16'h0001, 16'h0000};
    exp_t e; bit seen; int lat;
    for (int i = 0; i < 16; i++) begin
      issue(ops[i], av[i], bv[i], $sformatf("op%0d_%0d", ops[i], i), seen, lat);
      e = sb.pop_front();
      total++;
      if (!seen || lat != e.lat) begin
        bad++; $display("FAIL %s latency: got %0d seen=%0b want %0d", e.name, lat, seen, e.lat);
      end
      total++;
      if (bus.res_lo !== e.lo || bus.res_hi !== e.hi) begin
        bad++; $display("FAIL %s result: got %h_%h want %h_%h", e.name, bus.res_hi, bus.res_lo, e.hi, e.lo);
      end
      total++;
      if (bus.flags !== e.fl) begin
        bad++; $display("FAIL %s flags: got %b want %b", e.name, bus.flags, e.fl);
      end
      @(negedge clk);
      total++;
      if (bus.res_valid !== 1'b0) begin
        bad++; $display("FAIL %s pulse: res_valid got %b want 0", e.name, bus.res_valid);
      end
    end
  endtask

  // Multiplies: latency W, ready low while busy, ADD requests during MUL ignored
  task automatic test_mpy();
    logic [W-1:0] av[3] = '{16'h8000, 16'hFFFD, 16'h0000};
    logic [W-1:0] bv[3] = '{16'h8000, 16'h0007, 16'h1234};
    exp_t e; int j; int rdy_bad;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.op_valid = 1'b1; bus.op_code = OP_MPY; bus.a_in = av[i]; bus.b_in = bv[i];
      push_exp(OP_MPY, av[i], bv[i], $sformatf("mpy%0d", i));
      @(posedge clk);
      @(negedge clk);
      bus.op_valid = (i == 1);
      bus.op_code = OP_ADD; bus.a_in = 16'h0001; bus.b_in = 16'h0001;
      j = 0; rdy_bad = 0;
      while (!bus.res_valid && j < W + 4) begin
        if (bus.op_ready !== 1'b0) rdy_bad++;
        if (j == 5) bus.op_valid = 1'b0;
        @(negedge clk);
        j++;
      end
      bus.op_valid = 1'b0;
      e = sb.pop_front();
      total++;
      if (bus.res_valid !== 1'b1 || j != e.lat) begin
        bad++; $display("FAIL %s latency: got %0d want %0d", e.name, j, e.lat);
      end
      total++;
      if (rdy_bad != 0 || bus.op_ready !== 1'b1) begin
        bad++; $display("FAIL %s ready: busy-high cycles %0d, ready at done %b want 0 and 1",
                        e.name, rdy_bad, bus.op_ready);
      end
      total++;
      if (bus.res_lo !== e.lo || bus.res_hi !== e.hi) begin
        bad++; $display("FAIL %s result: got %h_%h want %h_%h", e.name, bus.res_hi, bus.res_lo, e.hi, e.lo);
      end
      total++;
      if (bus.flags !== e.fl) begin
        bad++; $display("FAIL %s flags: got %b want %b", e.name, bus.flags, e.fl);
      end
      repeat (2) @(negedge clk);
      total++;
      if (bus.res_valid !== 1'b0 || bus.res_lo !== e.lo) begin
        bad++; $display("FAIL %s after: valid=%b lo=%h want 0 %h", e.name, bus.res_valid, bus.res_lo, e.lo);
      end
    end
  endtask

  // Random single-cycle ops accepted on consecutive edges
  task automatic test_back_to_back();
    exp_t e; logic [3:0] op; logic [W-1:0] a, b;
    for (int i = 0; i <= 24; i++) begin
      @(negedge clk);
      if (i > 0) begin
        e = sb.pop_front();
        total++;
        if (bus.res_valid !== 1'b1 || bus.res_lo !== e.lo || bus.res_hi !== e.hi || bus.flags !== e.fl) begin
          bad++; $display("FAIL %s: got v=%b %h_%h f=%b want v=1 %h_%h f=%b", e.name, bus.res_valid,
                          bus.res_hi, bus.res_lo, bus.flags, e.hi, e.lo, e.fl);
        end
      end
      if (i < 24) begin
        op = 4'($urandom_range(0, 15));
        if (op == OP_MPY) op = OP_SUB;
        a = 16'($urandom); b = 16'($urandom);
        if (i % 6 == 0) begin a = 16'h7FFF; b = 16'hFFFF; end
        bus.op_valid = 1'b1; bus.op_code = op; bus.a_in = a; bus.b_in = b;
        push_exp(op, a, b, $sformatf("b2b%0d_op%0d", i, op));
      end else begin
        bus.op_valid = 1'b0;
      end
    end
  endtask

  // Reset asserted mid-multiply: immediate reset outputs, no strobe, then normal operation
  task automatic test_reset_mid_mpy();
    exp_t e; bit seen; int lat; int stray;
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op_code = OP_MPY; bus.a_in = 16'h0123; bus.b_in = 16'h0456;
    push_exp(OP_MPY, 16'h0123, 16'h0456, "mpy_abort");
    @(posedge clk);
    @(negedge clk);
    bus.op_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    e = sb.pop_back();
    m_lo = '0; m_hi = '0; m_fl = 4'b0010;
    total++;
    if (bus.res_lo !== '0 || bus.res_hi !== '0 || bus.flags !== 4'b0010) begin
      bad++; $display("FAIL rst_mid outputs: got %h_%h f=%b want 0000_0000 f=0010",
                      bus.res_hi, bus.res_lo, bus.flags);
    end
    total++;
    if (bus.op_ready !== 1'b1 || bus.res_valid !== 1'b0) begin
      bad++; $display("FAIL rst_mid hs: got ready=%b valid=%b want 1 0", bus.op_ready, bus.res_valid);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int k = 0; k < W + 4; k++) begin
      @(negedge clk);
      if (bus.res_valid !== 1'b0) stray++;
    end
    total++;
    if (stray != 0) begin
      bad++; $display("FAIL rst_mid stray: res_valid cycles got %0d want 0", stray);
    end
    issue(OP_ADD, 16'h0002, 16'h0003, "add_after_rst", seen, lat);
    e = sb.pop_front();
    total++;
    if (!seen || bus.res_lo !== 16'h0005 || bus.res_lo !== e.lo || bus.flags !== e.fl) begin
      bad++; $display("FAIL %s: got seen=%b lo=%h f=%b want 1 0005 f=%b", e.name, seen,
                      bus.res_lo, bus.flags, e.fl);
    end
  endtask

  initial begin
    bus.op_valid = 1'b0; bus.op_code = 4'd0; bus.a_in = '0; bus.b_in = '0;
    test_reset();
    test_single();
    test_mpy();
    test_back_to_back();
    test_reset_mid_mpy();
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL scoreboard leftover: got %0d want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/param_alu.md
PARAM_ALU -- requirements
Module: param_alu

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits; legal range 4..32.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 op_valid  input  1  operation request.
REQ-005 op_ready  output  1  block can accept an operation.
REQ-006 op_code  input  4  operation select (see REQ-011).
REQ-007 a_in  input  WIDTH  operand A (accumulator side), two's complement.
REQ-008 b_in  input  WIDTH  operand B (buffer-register side), two's complement.
REQ-009 res_lo / res_hi  output  WIDTH each  registered result, low and high halves.
REQ-010 res_valid  output  1  one-cycle pulse: res_lo/res_hi/flags just updated.
REQ-010a flags  output  4  registered flags: [0] N, [1] Z, [2] V, [3] H (res_hi holds a product).

Function
REQ-011 Opcodes: 1 CLR, 2 ADD, 3 SUB, 4 MPY (signed), 5 AND, 6 OR, 7 NOT A, 8 SHL logical by 1, 9 SHR logical by 1, 10 SAR arithmetic by 1, 11 CMP (A-B, flags only); 0 and 12-15 are NOP.
REQ-012 An operation is accepted on a rising edge with op_valid=1 and op_ready=1; operands and op_code are sampled only at acceptance.
REQ-013 FSM states IDLE and MUL; op_ready=1 only in IDLE; IDLE->MUL on accepted MPY; MUL->IDLE on the edge writing the product.
REQ-014 Single-cycle ops (all except MPY): results, flags and res_valid=1 visible after the acceptance edge k; block stays IDLE.
REQ-015 MPY: one iteration per cycle; product, flags and res_valid=1 visible after edge k+WIDTH; op_ready=0 from after edge k until after edge k+WIDTH.
REQ-016 MPY result {res_hi,res_lo} equals the exact 2*WIDTH-bit signed product, including most-negative x most-negative.
REQ-017 op_valid while op_ready=0 is ignored; no queuing.
REQ-018 Flags are computed from the new result, never the previous one: N = MSB of result (res_hi MSB for MPY); Z = 1 iff result is zero (all 2*WIDTH bits for MPY).
REQ-019 V: ADD = operands same sign and result sign differs; SUB/CMP = operands differ in sign and result sign differs from A; all other ops V=0.
REQ-020 H=1 after MPY, 0 after every other non-NOP op.
REQ-021 Non-MPY ops except CMP and NOP write res_hi=0.
REQ-022 CLR: res_lo=0, res_hi=0, flags=4'b0010.
REQ-023 CMP: flags updated as SUB; res_lo/res_hi unchanged; res_valid pulses.
REQ-024 NOP: res_lo, res_hi and flags unchanged; res_valid pulses.
REQ-025 ADD/SUB wrap modulo 2^WIDTH.

Reset
REQ-026 On rst_n=0, immediately: state IDLE, res_lo=0, res_hi=0, flags=4'b0010, res_valid=0, op_ready=1.
REQ-027 Reset during MUL aborts the multiply; no res_valid is produced for the aborted operation.
REQ-028 First acceptance occurs no earlier than the first rising edge after rst_n deasserts.

Structure
REQ-029 Shared package alu_pkg holds opcode constants, flag bit indices and the FSM state type.
REQ-030 Sequential multiplier is a sub-module alu_mul_seq (start, WIDTH-cycle iterate, done, 2*WIDTH product), instantiated once.

Verification (WIDTH=16)
REQ-031 ADD a=0x7FFF b=0x0001 -> res_lo=0x8000, res_hi=0, flags=4'b0101, res_valid one cycle after accept.
REQ-032 SUB a=0x0005 b=0x0005 -> res_lo=0x0000, flags=4'b0010; CMP a=0x0003 b=0x0005 -> res unchanged, flags=4'b0001.
REQ-033 MPY a=0x8000 b=0x8000 -> res_hi=0x4000, res_lo=0x0000, flags=4'b1000, res_valid 16 cycles after accept, op_ready=0 for 16 cycles.
REQ-034 MPY a=0xFFFD(-3) b=0x0007 -> res_hi=0xFFFF, res_lo=0xFFEB, flags=4'b1001; op_valid with ADD during MUL ignored.
REQ-035 SAR a=0x8004 -> 0xC002, flags=4'b0001; SHR a=0x8004 -> 0x4002, flags=4'b0000.
REQ-036 rst_n pulsed low 5 cycles into MPY -> outputs at reset values immediately, op_ready=1, no res_valid; next ADD 2+3 -> res_lo=0x0005.
